// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour playback path: FSM encodings,
// command opcodes, headings, default responses and the one-hot move decode
// helpers that the solver also uses.
package tour_pkg;

  // FSM state encodings, kept as plain constants for legacy compatibility
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t VERT  = 3'd1;
  localparam state_t HOLDV = 3'd2;
  localparam state_t HORZ  = 3'd3;
  localparam state_t HOLDH = 3'd4;

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_MOVE_FF = 4'b0011;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;

  localparam logic [7:0] RESP_ACK_DEF = 8'hA5;
  localparam logic [7:0] RESP_POS_DEF = 8'h5A;

  // One-hot move -> signed x step (east positive); 0 for any non-one-hot code
  function automatic logic signed [2:0] move_dx(input logic [7:0] mv);
    case (mv)
      8'h01:   move_dx = 3'sd1;
      8'h02:   move_dx = -3'sd1;
      8'h04:   move_dx = -3'sd2;
      8'h08:   move_dx = -3'sd2;
      8'h10:   move_dx = -3'sd1;
      8'h20:   move_dx = 3'sd1;
      8'h40:   move_dx = 3'sd2;
      8'h80:   move_dx = 3'sd2;
      default: move_dx = 3'sd0;
    endcase
  endfunction

  // One-hot move -> signed y step (north positive); 0 for any non-one-hot code
  function automatic logic signed [2:0] move_dy(input logic [7:0] mv);
    case (mv)
      8'h01:   move_dy = 3'sd2;
      8'h02:   move_dy = 3'sd2;
      8'h04:   move_dy = 3'sd1;
      8'h08:   move_dy = -3'sd1;
      8'h10:   move_dy = -3'sd2;
      8'h20:   move_dy = -3'sd2;
      8'h40:   move_dy = -3'sd1;
      8'h80:   move_dy = 3'sd1;
      default: move_dy = 3'sd0;
    endcase
  endfunction

  // Magnitude of a step as a 4-bit square count
  function automatic logic [3:0] step_mag(input logic signed [2:0] d);
    logic signed [2:0] a;
    a = d[2] ? -d : d;
    step_mag = {1'b0, a};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Combinational decode of one one-hot knight move into its two motion legs.
// Non-one-hot codes are flagged on bad_move; the legs produced for them are
// not meaningful and the consumer substitutes null legs.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        bad_move
);

  logic signed [2:0] dx;
  logic signed [2:0] dy;

  // Decode step sizes and build the vertical then horizontal legs
  always_comb begin
    dx       = move_dx(move);
    dy       = move_dy(move);
    bad_move = (move == 8'h00) || ((move & (move - 8'd1)) != 8'h00);
    vert_cmd = {OP_MOVE, (dy > 3'sd0) ? HDG_N : HDG_S, step_mag(dy)};
    horz_cmd = {OP_MOVE_FF, (dx > 3'sd0) ? HDG_E : HDG_W, step_mag(dx)};
  end

endmodule

// File: rtl/tour_cmd.sv
// Tour playback command generator. Walks the solver's move list and issues a
// vertical then a horizontal leg per move; transparent UART mux when idle.
// Optional build macro: TOUR_CMD_ABORT_EN (a UART command during a tour ends
// playback at the next leg completion).
module tour_cmd
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24,
  parameter logic [7:0]  RESP_ACK  = RESP_ACK_DEF,
  parameter logic [7:0]  RESP_POS  = RESP_POS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  state_t      state_q, state_d;
  logic [4:0]  indx_q, indx_d;
  logic [15:0] vert_cmd, horz_cmd;
  logic        bad_move;
  logic        last_move;
  logic        abort;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .bad_move (bad_move)
  );

  assign last_move = (indx_q == 5'(NUM_MOVES - 1));
  assign mv_indx   = indx_q;

`ifdef TOUR_CMD_ABORT_EN
  logic abort_q;

  // Remember a UART command arriving mid-tour; dropped when IDLE is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
    end else if (state_d == IDLE) begin
      abort_q <= 1'b0;
    end else if (state_q != IDLE && cmd_rdy_UART) begin
      abort_q <= 1'b1;
    end
  end

  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  // Next-state and move index sequencing
  always_comb begin
    state_d = state_q;
    indx_d  = indx_q;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          state_d = VERT;
          indx_d  = 5'd0;
        end
      end
      VERT:  if (clr_cmd_rdy) state_d = HOLDV;
      HOLDV: if (send_resp) state_d = abort ? IDLE : HORZ;
      HORZ:  if (clr_cmd_rdy) state_d = HOLDH;
      HOLDH: begin
        if (send_resp) begin
          if (last_move || abort) begin
            state_d = IDLE;
          end else begin
            state_d = VERT;
            indx_d  = indx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      indx_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      indx_q  <= indx_d;
    end
  end

  // Output mux: UART passthrough in IDLE, tour legs otherwise
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    case (state_q)
      IDLE: begin
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_ACK;
      end
      VERT, HOLDV: begin
        cmd     = bad_move ? {OP_MOVE, HDG_N, 4'd0} : vert_cmd;
        cmd_rdy = (state_q == VERT);
        if (state_q == HOLDV && send_resp && abort) resp = RESP_ACK;
      end
      HORZ, HOLDH: begin
        cmd     = bad_move ? {OP_MOVE_FF, HDG_N, 4'd0} : horz_cmd;
        cmd_rdy = (state_q == HORZ);
        if (state_q == HOLDH && send_resp && (last_move || abort)) resp = RESP_ACK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: UART passthrough, full tour playback with a
// processor model, odd move codes, mid-tour reset and mid-tour UART traffic.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  move_tab [24];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          rises = 0;
  logic        prev_rdy = 1'b0;

  always #5 clk = ~clk;

  tour_cmd dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  // Solver readout model: move is a combinational lookup on mv_indx
  always_comb move = (mv_indx < 5'd24) ? move_tab[mv_indx] : 8'h00;

  // Count cmd_rdy rising edges
  always @(negedge clk) begin
    if (cmd_rdy && !prev_rdy) rises++;
    prev_rdy = cmd_rdy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference leg for a move code
  function automatic logic [15:0] leg_model(input logic [7:0] m, input bit vert);
    int dx, dy;
    bit bad = 1'b0;
    case (m)
      8'h01: begin dx = 1;  dy = 2;  end
      8'h02: begin dx = -1; dy = 2;  end
      8'h04: begin dx = -2; dy = 1;  end
      8'h08: begin dx = -2; dy = -1; end
      8'h10: begin dx = -1; dy = -2; end
      8'h20: begin dx = 1;  dy = -2; end
      8'h40: begin dx = 2;  dy = -1; end
      8'h80: begin dx = 2;  dy = 1;  end
      default: begin dx = 0; dy = 0; bad = 1'b1; end
    endcase
    if (bad) return vert ? 16'h2000 : 16'h3000;
    if (vert) return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
  endfunction

  task automatic push_tour();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      exp_q.push_back(leg_model(move_tab[i], 1'b1));
      exp_q.push_back(leg_model(move_tab[i], 0));
    end
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  // Processor model; entered and left on a falling edge. Hooks: raise
  // cmd_rdy_UART at uart_leg, pulse start_tour after start_leg, and return
  // without acknowledging completion at stop_leg.
  task automatic run_legs(input int n_legs, input int uart_leg, input int start_leg,
                          input int stop_leg);
    for (int k = 0; k < n_legs; k++) begin
      int w;
      logic [15:0] e;
      w = 0;
      while (!cmd_rdy && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!cmd_rdy) begin
        check("leg_wait", {31'd0, cmd_rdy}, 32'd1);
        return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("leg_cmd", {16'd0, cmd}, {16'd0, e});
      check("leg_indx", {27'd0, mv_indx}, 32'(k / 2));
      if (k == uart_leg) cmd_rdy_UART = 1'b1;
      clr_cmd_rdy = 1'b1;
      #1 check("clr_uart_blocked", {31'd0, clr_cmd_rdy_UART}, 32'd0);
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      check("hold_rdy_low", {31'd0, cmd_rdy}, 32'd0);
      if (k == start_leg) begin
        pulse_start();
        check("start_ignored", {27'd0, mv_indx}, 32'(k / 2));
      end
      if (k == stop_leg) return;
      repeat (2) @(negedge clk);
      send_resp = 1'b1;
      #1 check("leg_resp", {24'd0, resp}, (k == n_legs - 1) ? 32'hA5 : 32'h5A);
      @(negedge clk);
      send_resp = 1'b0;
    end
  endtask

  initial begin
    int base;
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h0000;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    for (int i = 0; i < 24; i++) move_tab[i] = 8'h01 << (i % 8);
    move_tab[8]  = 8'h00;
    move_tab[9]  = 8'h03;
    move_tab[10] = 8'hFF;

    repeat (2) @(negedge clk);
    check("rst_indx", {27'd0, mv_indx}, 32'd0);
    check("rst_resp", {24'd0, resp}, 32'hA5);
    check("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle passthrough
    cmd_UART     = 16'h2003;
    cmd_rdy_UART = 1'b1;
    #1;
    check("idle_cmd", {16'd0, cmd}, 32'h2003);
    check("idle_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("idle_resp", {24'd0, resp}, 32'hA5);
    clr_cmd_rdy = 1'b1;
    #1 check("idle_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
    @(negedge clk);
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;
    @(negedge clk);

    // Full tour, including odd move codes
    push_tour();
    base = rises;
    pulse_start();
    run_legs(48, -1, -1, -1);
    check("tour_rises", 32'(rises - base), 32'd48);
    check("tour_q_empty", 32'(exp_q.size()), 32'd0);
    check("tour_end_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("tour_end_resp", {24'd0, resp}, 32'hA5);
    check("tour_end_cmd", {16'd0, cmd}, 32'h2003);

    // Mid-tour start ignored; asynchronous reset in HOLDH at index 9
    cmd_UART = 16'h1234;
    push_tour();
    pulse_start();
    run_legs(48, -1, 6, 19);
    check("pre_rst_indx", {27'd0, mv_indx}, 32'd9);
    rst_n = 1'b0;
    #1;
    check("arst_indx", {27'd0, mv_indx}, 32'd0);
    check("arst_resp", {24'd0, resp}, 32'hA5);
    check("arst_cmd", {16'd0, cmd}, 32'h1234);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // UART command arriving during HORZ of move 5
    cmd_UART = 16'h4321;
    push_tour();
    pulse_start();
`ifdef TOUR_CMD_ABORT_EN
    run_legs(12, 11, -1, -1);
`else
    run_legs(48, 11, -1, -1);
    check("uart_q_empty", 32'(exp_q.size()), 32'd0);
`endif
    check("uart_fwd_cmd", {16'd0, cmd}, 32'h4321);
    check("uart_fwd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("uart_fwd_resp", {24'd0, resp}, 32'hA5);
    clr_cmd_rdy = 1'b1;
    #1 check("uart_fwd_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
    @(negedge clk);
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
